efb_wb_arbiter: RTL and testbench

Shares the single EFB Wishbone slave port (timer/counter registers) between two independent requesters, e.g. the timer-sampling state machine and the UART command path. It arbitrates round-robin, runs exactly one Wishbone cycle at a time, returns read data and a one-cycle completion pulse to the winning requester, and guarantees a bus-idle cycle between transactions. It sits between the requesters in top and the EFB Wishbone slave, in the 80 MHz PLL clock domain.

---
 rtl/efb_wb_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_efb_wb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/efb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// efb_wb_arbiter
//
// Shares the single EFB Wishbone slave port (timer/counter registers) between
// two independent requesters. Round-robin arbitration, exactly one Wishbone
// cycle in flight, a one-cycle completion pulse to the winner, and a forced
// bus-idle cycle (RECOVER) between transactions.
//
// Optional feature: define EFB_WB_ARB_TIMEOUT_EN to abort a cycle that has not
// been acknowledged after TIMEOUT_CYCLES cycles in ACTIVE. The abort reports
// o_Err=1 and read data of all ones. Without the macro ACTIVE waits for the
// ack indefinitely and o_Err is tied low.
//
// Ports:
//   i_Clock, i_Resetn         clock, synchronous active-low reset
//   i_ReqN/i_WeN/i_AddrN/     requester N request (level), write enable,
//   i_DataN, o_DoneN          address, write data, completion pulse
//   o_Rd_Data                 read data of the last completed read
//   o_Err                     qualifies o_DoneN: 1 = aborted by timeout
//   o_Busy                    high whenever the arbiter is not in IDLE
//   wb_*                      Wishbone master side towards the EFB slave
// -----------------------------------------------------------------------------
module efb_wb_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  i_Clock,
    input  logic                  i_Resetn,
    input  logic                  i_Req0,
    input  logic                  i_We0,
    input  logic [ADDR_WIDTH-1:0] i_Addr0,
    input  logic [DATA_WIDTH-1:0] i_Data0,
    output logic                  o_Done0,
    input  logic                  i_Req1,
    input  logic                  i_We1,
    input  logic [ADDR_WIDTH-1:0] i_Addr1,
    input  logic [DATA_WIDTH-1:0] i_Data1,
    output logic                  o_Done1,
    output logic [DATA_WIDTH-1:0] o_Rd_Data,
    output logic                  o_Err,
    output logic                  o_Busy,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Legal TIMEOUT_CYCLES range is 2..255; an out-of-range value leaves an
    // empty, visibly named block in the elaborated hierarchy.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
    end

    state_t                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    done0_q, done0_d;
    logic                    done1_q, done1_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    sel1;

`ifdef EFB_WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic                    err_q, err_d;
    logic [7:0]              tmo_cnt_q, tmo_cnt_d;
`endif

    // Requester 1 wins when it is alone, or when both ask and 0 won last time.
    assign sel1 = i_Req1 && !(i_Req0 && last_grant_q);

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        rd_data_d    = rd_data_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
`ifdef EFB_WB_ARB_TIMEOUT_EN
        err_d        = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_Req0 || i_Req1) begin
                    grant_d = sel1;
                    we_d    = sel1 ? i_We1   : i_We0;
                    adr_d   = sel1 ? i_Addr1 : i_Addr0;
                    dat_d   = sel1 ? i_Data1 : i_Data0;
                    cyc_d   = 1'b1;
                    state_d = ST_ACTIVE;
`ifdef EFB_WB_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            ST_ACTIVE: begin
                if (wb_ack_i) begin
                    cyc_d        = 1'b0;
                    if (!we_q) begin
                        rd_data_d = wb_dat_i;
                    end
                    done0_d      = !grant_q;
                    done1_d      = grant_q;
                    last_grant_d = grant_q;
                    state_d      = ST_RECOVER;
                end
`ifdef EFB_WB_ARB_TIMEOUT_EN
                // An ack in the expiry cycle takes the branch above instead.
                else if (tmo_cnt_q == TMO_LAST) begin
                    cyc_d        = 1'b0;
                    rd_data_d    = '1;
                    err_d        = 1'b1;
                    done0_d      = !grant_q;
                    done1_d      = grant_q;
                    last_grant_d = grant_q;
                    state_d      = ST_RECOVER;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end

            ST_RECOVER: begin
                state_d = ST_IDLE;
            end

            default: begin
                cyc_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Resetn) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            rd_data_q    <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef EFB_WB_ARB_TIMEOUT_EN
            err_q        <= 1'b0;
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            rd_data_q    <= rd_data_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
`ifdef EFB_WB_ARB_TIMEOUT_EN
            err_q        <= err_d;
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign o_Done0   = done0_q;
    assign o_Done1   = done1_q;
    assign o_Rd_Data = rd_data_q;
    assign o_Busy    = (state_q != ST_IDLE);
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
`ifdef EFB_WB_ARB_TIMEOUT_EN
    assign o_Err     = err_q;
`else
    assign o_Err     = 1'b0;
`endif

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_efb_wb_arbiter
//
// Directed bench for efb_wb_arbiter. Stimulus pushes the expected Wishbone
// cycle (we/adr/dat) and the expected completion (requester, err, read data)
// into two queues; a monitor on the falling edge pops and compares whenever
// a cycle starts or a done pulse appears. A small slave model acks after a
// programmable number of ACTIVE cycles.
// -----------------------------------------------------------------------------
module tb_efb_wb_arbiter;

    typedef struct packed {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
    } bus_t;

    typedef struct packed {
        logic       idx;
        logic       err;
        logic [7:0] rd;
    } done_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, data0, addr1, data1;
    logic       done0, done1, err, busy;
    logic [7:0] rd_data;
    logic       cyc, stb, wwe;
    logic [7:0] wadr, wdat_o, wdat_i;
    logic       ack;

    logic       slave_en;
    int         slave_delay;
    logic [7:0] slave_rdata;
    logic       slave_ack;
    logic       stray_ack;
    logic       mon_en = 1'b0;

    bus_t  exp_bus[$];
    done_t exp_done[$];

    int n_cmp = 0;
    int n_err = 0;

    assign ack    = slave_ack | stray_ack;
    assign wdat_i = slave_rdata;

    always #5 clk = ~clk;

    efb_wb_arbiter #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_Clock  (clk),
        .i_Resetn (resetn),
        .i_Req0   (req0),
        .i_We0    (we0),
        .i_Addr0  (addr0),
        .i_Data0  (data0),
        .o_Done0  (done0),
        .i_Req1   (req1),
        .i_We1    (we1),
        .i_Addr1  (addr1),
        .i_Data1  (data1),
        .o_Done1  (done1),
        .o_Rd_Data(rd_data),
        .o_Err    (err),
        .o_Busy   (busy),
        .wb_cyc_o (cyc),
        .wb_stb_o (stb),
        .wb_we_o  (wwe),
        .wb_adr_o (wadr),
        .wb_dat_o (wdat_o),
        .wb_dat_i (wdat_i),
        .wb_ack_i (ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks at least once, then until a done pulse is visible or budget runs out.
    task automatic wait_done(output int cycles, input int budget);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!(done0 || done1) && cycles < budget);
        if (!(done0 || done1)) begin
            chk("done_wait_timeout", 32'd0, 32'd1);
        end
    endtask

    // Slave: acks once the cycle has been up for slave_delay cycles.
    initial begin : slave_model
        int cnt;
        cnt       = 0;
        slave_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc) begin
                slave_ack = slave_en && (cnt >= slave_delay);
                cnt++;
            end else begin
                slave_ack = 1'b0;
                cnt       = 0;
            end
        end
    end

    // Monitor: compares bus cycles and completions against the queues.
    initial begin : monitor
        logic  prev_cyc;
        bus_t  cur;
        done_t d;
        prev_cyc = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (cyc) begin
                    if (!prev_cyc) begin
                        if (exp_bus.size() == 0) begin
                            chk("unexpected_bus_cycle", 32'd1, 32'd0);
                            cur = '{we: wwe, adr: wadr, dat: wdat_o};
                        end else begin
                            cur = exp_bus.pop_front();
                        end
                    end
                    chk("bus_stb", {31'd0, stb}, 32'd1);
                    chk("bus_we",  {31'd0, wwe}, {31'd0, cur.we});
                    chk("bus_adr", {24'd0, wadr}, {24'd0, cur.adr});
                    chk("bus_dat", {24'd0, wdat_o}, {24'd0, cur.dat});
                end
                prev_cyc = cyc;

                if (done0 && done1) begin
                    chk("done_both_high", 32'd1, 32'd0);
                end
                if (done0 || done1) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_idx", {31'd0, done1}, {31'd0, d.idx});
                        chk("done_err", {31'd0, err}, {31'd0, d.err});
                        chk("done_rd_data", {24'd0, rd_data}, {24'd0, d.rd});
                    end
                end else begin
                    chk("err_idle_low", {31'd0, err}, 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int c;
        resetn      = 1'b0;
        req0        = 1'b0; we0 = 1'b0; addr0 = '0; data0 = '0;
        req1        = 1'b0; we1 = 1'b0; addr1 = '0; data1 = '0;
        slave_en    = 1'b1;
        slave_delay = 0;
        slave_rdata = '0;
        stray_ack   = 1'b0;

        // Reset values.
        tick(); tick();
        mon_en = 1'b1;
        chk("rst_ctrl", {25'd0, cyc, stb, wwe, busy, done0, done1, err}, 32'd0);
        chk("rst_adr", {24'd0, wadr}, 32'd0);
        chk("rst_dat", {24'd0, wdat_o}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        resetn = 1'b1;
        tick();

        // Single read, slave acks 2 cycles after stb with A5.
        slave_delay = 2; slave_rdata = 8'hA5;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h66; data0 = 8'h11;
        exp_bus.push_back('{we: 1'b0, adr: 8'h66, dat: 8'h11});
        exp_done.push_back('{idx: 1'b0, err: 1'b0, rd: 8'hA5});
        tick();
        chk("rd_latency_cyc", {31'd0, cyc}, 32'd1);
        chk("rd_latency_busy", {31'd0, busy}, 32'd1);
        addr0 = 8'h00;   // latched address must hold
        wait_done(c, 20);
        chk("rd_ack_wait", c, 32'd3);
        req0 = 1'b0;
        chk("rd_recover_cyc", {31'd0, cyc}, 32'd0);
        chk("rd_recover_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("rd_done_one_cycle", {30'd0, done0, done1}, 32'd0);
        chk("rd_back_idle", {31'd0, busy}, 32'd0);

        // Write on requester 1: read data must stay A5.
        slave_delay = 0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h5E; data1 = 8'h3C;
        exp_bus.push_back('{we: 1'b1, adr: 8'h5E, dat: 8'h3C});
        exp_done.push_back('{idx: 1'b1, err: 1'b0, rd: 8'hA5});
        wait_done(c, 20);
        req1 = 1'b0;
        tick(); tick();

        // Stray ack in IDLE.
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        chk("stray_ack_cyc", {31'd0, cyc}, 32'd0);
        chk("stray_ack_busy", {31'd0, busy}, 32'd0);
        chk("stray_ack_done", {30'd0, done0, done1}, 32'd0);
        tick();

        // Contention right after reset: grants alternate 0,1,0,1, 3 cycles apart.
        resetn = 1'b0; tick(); resetn = 1'b1; tick();
        slave_rdata = 8'h77;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; data0 = 8'h00;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; data1 = 8'h9C;
        for (int k = 0; k < 2; k++) begin
            exp_bus.push_back('{we: 1'b0, adr: 8'h10, dat: 8'h00});
            exp_bus.push_back('{we: 1'b1, adr: 8'h20, dat: 8'h9C});
            exp_done.push_back('{idx: 1'b0, err: 1'b0, rd: 8'h77});
            exp_done.push_back('{idx: 1'b1, err: 1'b0, rd: 8'h77});
        end
        for (int k = 0; k < 4; k++) begin
            wait_done(c, 20);
            if (k > 0) chk("b2b_spacing", c, 32'd3);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

        // Held request: next cycle starts exactly 2 cycles after the done pulse.
        slave_rdata = 8'h5A;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h33; data0 = 8'h00;
        for (int k = 0; k < 2; k++) begin
            exp_bus.push_back('{we: 1'b0, adr: 8'h33, dat: 8'h00});
            exp_done.push_back('{idx: 1'b0, err: 1'b0, rd: 8'h5A});
        end
        wait_done(c, 20);
        tick();
        chk("held_gap_idle", {31'd0, cyc}, 32'd0);
        tick();
        chk("held_restart", {31'd0, cyc}, 32'd1);
        req0 = 1'b0;
        wait_done(c, 20);
        tick(); tick();

        // Reset mid-transaction with no ack; late ack ignored; Req0 wins after.
        slave_en = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h44; data0 = 8'h00;
        exp_bus.push_back('{we: 1'b0, adr: 8'h44, dat: 8'h00});
        tick();
        chk("mid_rst_active", {31'd0, cyc}, 32'd1);
        tick(); tick();
        resetn = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h55; data1 = 8'h00;
        tick();
        chk("mid_rst_ctrl", {28'd0, cyc, stb, busy, done0 | done1}, 32'd0);
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        slave_en = 1'b1; slave_delay = 0; slave_rdata = 8'h66;
        exp_bus.push_back('{we: 1'b0, adr: 8'h44, dat: 8'h00});
        exp_done.push_back('{idx: 1'b0, err: 1'b0, rd: 8'h66});
        resetn = 1'b1;
        tick();
        chk("post_rst_grant_cyc", {31'd0, cyc}, 32'd1);
        chk("post_rst_grant_adr", {24'd0, wadr}, 32'h44);
        wait_done(c, 20);
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

`ifdef EFB_WB_ARB_TIMEOUT_EN
        // Timeout with no ack, then ack landing exactly on the expiry cycle.
        slave_en = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h70; data0 = 8'h00;
        exp_bus.push_back('{we: 1'b0, adr: 8'h70, dat: 8'h00});
        exp_done.push_back('{idx: 1'b0, err: 1'b1, rd: 8'hFF});
        tick();
        req0 = 1'b0;
        wait_done(c, 20);
        chk("tmo_cycles", c, 32'd4);
        tick(); tick();
        slave_en = 1'b1; slave_delay = 3; slave_rdata = 8'h42;
        req0 = 1'b1;
        exp_bus.push_back('{we: 1'b0, adr: 8'h70, dat: 8'h00});
        exp_done.push_back('{idx: 1'b0, err: 1'b0, rd: 8'h42});
        tick();
        req0 = 1'b0;
        wait_done(c, 20);
        chk("tmo_ack_at_expiry_cycles", c, 32'd4);
        tick(); tick();
`endif

        tick(); tick();
        chk("bus_queue_empty", exp_bus.size(), 32'd0);
        chk("done_queue_empty", exp_done.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
